// File: rtl/cla_pkg.sv
// Shared widths and types for the 16-bit two-level carry-lookahead adder.
package cla_pkg;

    localparam int WIDTH     = 16;
    localparam int GROUP     = 4;
    localparam int NGROUPS   = 4;
    localparam int OUT_WIDTH = 17;

    typedef logic [WIDTH-1:0]     operand_t;
    typedef logic [OUT_WIDTH-1:0] result_t;

endpackage

// File: rtl/cla_4b_group.sv
// 4-bit lookahead group: internal carries are flat sum-of-products, never rippled,
// and the group exports its generate/propagate for the second lookahead level.
module cla_4b_group
    import cla_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             gg,
    output logic             gp
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

endmodule

// File: rtl/cla_16b.sv
// 16-bit two-level carry-lookahead adder with carry-in and a registered 17-bit
// result {carry_out, sum}; one cycle of latency, one addition per cycle.
module cla_16b
    import cla_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  operand_t in0,
    input  operand_t in1,
    input  logic     in2,
    output result_t  out0
);

    operand_t           sum;
    logic [NGROUPS-1:0] gg;
    logic [NGROUPS-1:0] gp;
    logic [NGROUPS:0]   carry;

    // Second lookahead level: every group carry is two gate levels from GG/GP.
    assign carry[0] = in2;
    assign carry[1] = gg[0] | (gp[0] & in2);
    assign carry[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & in2);
    assign carry[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                    | (gp[2] & gp[1] & gp[0] & in2);
    assign carry[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                    | (gp[3] & gp[2] & gp[1] & gg[0])
                    | (gp[3] & gp[2] & gp[1] & gp[0] & in2);

    for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
        cla_4b_group u_group (
            .a   (in0[gi*GROUP +: GROUP]),
            .b   (in1[gi*GROUP +: GROUP]),
            .cin (carry[gi]),
            .sum (sum[gi*GROUP +: GROUP]),
            .gg  (gg[gi]),
            .gp  (gp[gi])
        );
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out0 <= '0;
        end else begin
            out0 <= {carry[NGROUPS], sum};
        end
    end

endmodule

// File: tb/tb_cla_16b.sv
// Self-checking bench for cla_16b: directed vectors with hand-computed results,
// then a short random sweep against a 17-bit behavioral sum.
module tb_cla_16b;

    import cla_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    operand_t in0;
    operand_t in1;
    logic     in2;
    result_t  out0;

    int n_checks = 0;
    int n_passed = 0;

    cla_16b dut (
        .clk  (clk),
        .rst  (rst),
        .in0  (in0),
        .in1  (in1),
        .in2  (in2),
        .out0 (out0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input result_t got, input result_t exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%05h, expected 0x%05h", tag, got, exp);
        end
    endtask

    // Drive one operand triple, clock it in, sample 1 ns after the edge.
    task automatic add(input string tag, input operand_t a, input operand_t b,
                       input logic c, input result_t exp);
        in0 = a;
        in1 = b;
        in2 = c;
        @(posedge clk);
        #1;
        check(tag, out0, exp);
    endtask

    initial begin
        rst = 1'b1;
        in0 = 16'hFFFF;
        in1 = 16'hFFFF;
        in2 = 1'b1;

        // Reset must override all-ones operands on both edges.
        @(posedge clk);
        #1;
        check("reset_cycle1", out0, 17'h00000);
        @(posedge clk);
        #1;
        check("reset_cycle2", out0, 17'h00000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_reset", out0, 17'h1FFFF);

        add("zero",          16'h0000, 16'h0000, 1'b0, 17'h00000);
        add("carry_in_only", 16'h0000, 16'h0000, 1'b1, 17'h00001);
        add("gp_chain",      16'hFFFF, 16'h0000, 1'b1, 17'h10000);
        add("group0_carry",  16'h000F, 16'h0001, 1'b0, 17'h00010);
        add("group2_carry",  16'h0FFF, 16'h0001, 1'b0, 17'h01000);
        add("msb_carry",     16'h8000, 16'h8000, 1'b0, 17'h10000);
        add("alt_bits",      16'hAAAA, 16'h5555, 1'b1, 17'h10000);
        add("mid_groups",    16'h00F0, 16'h0F10, 1'b0, 17'h01000);

        // Back-to-back: inputs change every cycle, results follow one cycle later.
        add("pipe_5555",  16'd1234,  16'd4321,  1'b0, 17'd5555);
        add("pipe_65536", 16'd65535, 16'd1,     1'b0, 17'd65536);
        add("pipe_70001", 16'd40000, 16'd30000, 1'b1, 17'd70001);

        // Mid-stream reset discards the in-flight sum; next edge resumes normally.
        rst = 1'b1;
        add("midstream_reset", 16'h1234, 16'h1111, 1'b0, 17'h00000);
        rst = 1'b0;
        add("resume",          16'h1234, 16'h1111, 1'b1, 17'h02346);

        for (int i = 0; i < 2000; i++) begin
            operand_t a;
            operand_t b;
            logic     c;
            a = operand_t'($urandom);
            b = operand_t'($urandom);
            c = 1'($urandom);
            add("random", a, b, c, {1'b0, a} + {1'b0, b} + {16'b0, c});
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
